// File: rtl/cdc_ctrl_pkg.sv
// cdc_ctrl_pkg: shared FSM state type, synchroniser depth floor and round-robin pick for cdc_xfer_sched
package cdc_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_NACK, ABORT} xfer_state_t;
  localparam int SYNC_STAGES_MIN = 2;
  // Unused upper request bits are zero, so a mod-8 search visits requesters in the same order as a mod-N one
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] idx;
    rr_pick = last;
    for (int k = 8; k >= 1; k--) begin
      idx = last + 3'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/cdc_sync_ff.sv
// cdc_sync_ff: multi-stage flip-flop synchroniser for a single-bit asynchronous level
module cdc_sync_ff
  import cdc_ctrl_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);
  localparam int S = STAGES < SYNC_STAGES_MIN ? SYNC_STAGES_MIN : STAGES;
  logic [S-1:0] r_chain;
  always_ff @(posedge CLK) r_chain <= RST ? '0 : {r_chain[S-2:0], D};
  assign Q = r_chain[S-1];
endmodule

// File: rtl/cdc_xfer_sched.sv
// cdc_xfer_sched: round-robin scheduler of N requesters onto one 4-phase REQ/ACK clock crossing.
// Optional handshake watchdog with ABORT state enabled by defining CDC_TIMEOUT_EN.
module cdc_xfer_sched
  import cdc_ctrl_pkg::*;
#(
  parameter int N           = 3,
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] IDATA,
  output logic [N-1:0]   GNT,
  output logic [W-1:0]   XDATA,
  output logic           XREQ,
  input  logic           XACK,
  output logic           BUSY,
  output logic           ERR
);
  xfer_state_t  r_state;
  logic [2:0]   r_sel, r_last;
  logic [N-1:0] r_gnt;
  logic [W-1:0] r_xdata;
  logic         r_xreq;
  logic         w_ack_s, w_start, w_wait;
  logic [2:0]   w_pick;
  cdc_sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (.CLK(CLK), .RST(RST), .D(XACK), .Q(w_ack_s));
  assign w_pick  = rr_pick(8'(REQ), r_last);
  // A still-high acknowledge in IDLE holds off the next request until it clears
  assign w_start = r_state == IDLE && |REQ && !w_ack_s;
  assign w_wait  = r_state == WAIT_ACK || r_state == WAIT_NACK;
`ifdef CDC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_to;
  assign w_to = w_wait && r_cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge CLK) begin
    r_cnt <= (RST || w_start) ? '0 : w_wait ? r_cnt + CW'(1) : r_cnt;
    r_err <= !RST && w_to;
  end
  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_xreq  <= 1'b0;
      r_xdata <= '0;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_last  <= 3'(N - 1);
    end else begin
      r_gnt <= '0;
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= WAIT_ACK;
          r_xreq  <= 1'b1;
          r_sel   <= w_pick;
          r_xdata <= IDATA[w_pick*W +: W];
        end
        WAIT_ACK:
`ifdef CDC_TIMEOUT_EN
          if (w_to) begin
            r_state <= ABORT;
            r_xreq  <= 1'b0;
          end else
`endif
          if (w_ack_s) begin
            r_state <= WAIT_NACK;
            r_xreq  <= 1'b0;
          end
        WAIT_NACK:
`ifdef CDC_TIMEOUT_EN
          if (w_to) r_state <= ABORT;
          else
`endif
          if (!w_ack_s) begin
            r_state <= IDLE;
            r_gnt   <= N'(1) << r_sel;
            r_last  <= r_sel;
          end
`ifdef CDC_TIMEOUT_EN
        ABORT: if (!w_ack_s) r_state <= IDLE;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
  assign GNT   = r_gnt;
  assign XDATA = r_xdata;
  assign XREQ  = r_xreq;
  assign BUSY  = r_state != IDLE;
endmodule

// File: tb/tb_cdc_xfer_sched.sv
// tb_cdc_xfer_sched: directed and randomized checks of cdc_xfer_sched against a round-robin reference model
module tb_cdc_xfer_sched;
  localparam int N = 3;
  localparam int W = 4;
  logic           CLK = 1'b0, CLK2 = 1'b0, RST = 1'b1;
  logic [N-1:0]   REQ = '0;
  logic [N*W-1:0] IDATA = '0;
  logic [N-1:0]   GNT;
  logic [W-1:0]   XDATA;
  logic           XREQ, XACK, BUSY, ERR;
  logic           stall = 1'b0, d1 = 1'b0, d2 = 1'b0;
  logic [W-1:0]   dq[$];
  logic           pxreq = 1'b0;
  logic [W-1:0]   pxd = '0;
  int             n_chk = 0, n_fail = 0, m_last = N - 1;
  logic [N-1:0]   exp_rr [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  cdc_xfer_sched #(.N(N), .W(W), .SYNC_STAGES(2), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .IDATA(IDATA), .GNT(GNT), .XDATA(XDATA),
    .XREQ(XREQ), .XACK(XACK), .BUSY(BUSY), .ERR(ERR));

  always #5 CLK = ~CLK;
  always #8 CLK2 = ~CLK2;
  // Destination side: 2-FF receiver echoing XREQ back, capturing each word on the synchronised rise
  always @(posedge CLK2) begin
    if (d1 && !d2) dq.push_back(XDATA);
    d1 <= XREQ;
    d2 <= d1;
  end
  assign XACK = stall ? 1'b0 : d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (XREQ && pxreq) chk("xdata_stable", 32'(XDATA), 32'(pxd));
    pxreq = XREQ;
    pxd = XDATA;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    IDATA[i*W +: W] = v;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  // One full transfer: predicted winner/word at XREQ rise, then its completion pulse
  task automatic xfer(input string tag, input int exp_lat, input int drop_at);
    int e, lat;
    logic [W-1:0] w;
    e = pick(REQ, m_last);
    w = IDATA[e*W +: W];
    lat = 0;
    while (!XREQ && lat < 60) begin
      tick();
      lat++;
    end
    chk({tag, "_xreq_rise"}, 32'(XREQ), 32'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_xdata"}, 32'(XDATA), 32'(w));
    chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    chk({tag, "_gnt_at_rise"}, 32'(GNT), 32'd0);
    lat = 0;
    while (GNT == '0 && lat < 300) begin
      tick();
      lat++;
      if (lat == drop_at) REQ[e] = 1'b0;
    end
    chk({tag, "_gnt"}, 32'(GNT), 32'(1 << e));
    chk({tag, "_xreq_low"}, 32'(XREQ), 32'd0);
    m_last = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    repeat (3) tick();
    chk("rst_xreq", 32'(XREQ), 0);
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_xdata", 32'(XDATA), 0);
    RST = 1'b0;
    tick();
    REQ = 3'b001;
    set_word(0, 4'hA);
    xfer("t1", 1, -1);
    REQ = '0;
    tick();
    chk("t1_gnt_once", 32'(GNT), 0);
    repeat (3) tick();
    chk("t1_busy_after", 32'(BUSY), 0);
    chk("t1_xreq_after", 32'(XREQ), 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    m_last = N - 1;
    set_word(0, 4'h1);
    set_word(1, 4'h2);
    set_word(2, 4'h3);
    REQ = 3'b111;
    for (int k = 0; k < 4; k++) begin
      xfer("t2", 1, -1);
      chk("t2_rr_order", 32'(GNT), 32'(exp_rr[k]));
    end
    REQ = '0;
    repeat (4) tick();
    dq.delete();
    REQ = 3'b001;
    for (int i = 0; i < 16; i++) begin
      set_word(0, W'(i));
      xfer("t3", 1, -1);
    end
    REQ = '0;
    repeat (20) tick();
    chk("t3_count", dq.size(), 16);
    for (int i = 0; i < 16; i++) if (i < dq.size()) chk("t3_word", 32'(dq[i]), i);
    REQ = 3'b010;
    set_word(1, 4'h5);
    tick();
    chk("t4_xreq_up", 32'(XREQ), 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    REQ = '0;
    m_last = N - 1;
    chk("t4_xreq_drop", 32'(XREQ), 0);
    chk("t4_busy", 32'(BUSY), 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen |= |GNT;
      tick();
    end
    chk("t4_no_gnt", 32'(seen), 0);
    REQ = 3'b111;
    xfer("t4", 1, -1);
    chk("t4_req0_wins", 32'(GNT), 32'b001);
    REQ = 3'b010;
    set_word(1, 4'h7);
    xfer("t5", 1, 2);
    chk("t5_gnt1", 32'(GNT), 32'b010);
    repeat (6) tick();
    chk("t5_idle", 32'(BUSY), 0);
    for (int i = 0; i < 24; i++) begin
      REQ = N'($urandom_range(1, (1 << N) - 1));
      for (int j = 0; j < N; j++) set_word(j, W'($urandom));
      xfer("rnd", 1, -1);
    end
    REQ = '0;
    repeat (6) tick();
`ifdef CDC_TIMEOUT_EN
    RST = 1'b1;
    tick();
    RST = 1'b0;
    m_last = N - 1;
    stall = 1'b1;
    set_word(0, 4'h9);
    set_word(1, 4'h6);
    REQ = 3'b011;
    tick();
    chk("t6_xreq_up", 32'(XREQ), 1);
    n = 0;
    while (!ERR && n < 40) begin
      tick();
      n++;
    end
    chk("t6_err_latency", n, 16);
    chk("t6_xreq_fall", 32'(XREQ), 0);
    chk("t6_no_gnt", 32'(GNT), 0);
    stall = 1'b0;
    tick();
    chk("t6_err_pulse", 32'(ERR), 0);
    xfer("t6_retry", -1, -1);
    chk("t6_same_req", 32'(GNT), 32'b001);
    REQ = '0;
    repeat (6) tick();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
